// File: rtl/debug_uart_tx_fifo_pkg.sv
// Shared peripheral definitions for the debug UART transmitter: serializer
// state encoding and 8N1 frame constants.
package debug_uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

endpackage

// File: rtl/debug_uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and a separate occupancy count.
// Pushes are ignored while full and pops are ignored while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter: byte FIFO feeding an 8N1 serializer. Frames are sent
// back-to-back while bytes are queued; writes into a full FIFO set a sticky flag.
module debug_uart_tx_fifo
  import debug_uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 14_000_000,
  parameter int unsigned BIT_RATE = 9600,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [UART_DATA_BITS-1:0] wr_data,
  input  logic                      clr_overflow,
  output logic                      txd,
  output logic                      busy,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int unsigned DIV   = CLK_HZ / BIT_RATE;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("debug_uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("debug_uart_tx_fifo: DEPTH must be a power of two in 2..16");
  end

  tx_state_e                 state_q, state_d;
  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      overflow_q, overflow_d;

  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      div_done, last_stop;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign div_done  = (div_cnt_q == DIV_W'(DIV - 1));
  assign last_stop = (bit_cnt_q == BIT_W'(UART_STOP_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_done ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (fifo_pop) begin
          state_d = START;
          shift_d = fifo_rdata;
        end
      end
      START: begin
        if (div_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (div_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_W'(UART_DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (div_done) begin
          if (!last_stop) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (fifo_pop) begin
            state_d = START;
            shift_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the current state, so it trails the state by one
  // cycle; every bit, including the stop bit, still lasts exactly DIV cycles.
  always_comb begin
    fifo_pop = 1'b0;
    txd_d    = 1'b1;
    unique case (state_q)
      IDLE:    fifo_pop = !fifo_empty;
      START:   txd_d    = 1'b0;
      DATA:    txd_d    = shift_q[0];
      STOP:    fifo_pop = div_done && last_stop && !fifo_empty;
      default: txd_d    = 1'b1;
    endcase
  end

  // A dropped write wins over a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && fifo_full) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  assign txd      = txd_q;
  assign busy     = !fifo_empty || (state_q != IDLE);
  assign full     = fifo_full;
  assign level    = fifo_count;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed bench for debug_uart_tx_fifo at DIV=4, DEPTH=4; a line receiver
// decodes txd and the received bytes are compared with the expected byte list.
module tb_debug_uart_tx_fifo;

  localparam int unsigned CLK_HZ    = 1_000_000;
  localparam int unsigned BIT_RATE  = 250_000;
  localparam int unsigned DEPTH     = 4;
  localparam int          DIV       = 4;
  localparam int          FRAME_CYC = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_overflow;
  logic       txd;
  logic       busy;
  logic       full;
  logic [2:0] level;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rx_data_q[$];
  bit         rx_ok_q[$];
  int         rx_start_q[$];
  logic [7:0] exp_q[$];
  logic [2:0] b_lvl [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_uart_tx_fifo #(
    .CLK_HZ   (CLK_HZ),
    .BIT_RATE (BIT_RATE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .txd          (txd),
    .busy         (busy),
    .full         (full),
    .level        (level),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    rst_n        = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    rx_data_q.delete();
    rx_ok_q.delete();
    rx_start_q.delete();
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check({tag, "_drain"}, busy, 1'b0);
    repeat (DIV + 2) tick();
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_frames"}, rx_data_q.size(), exp_q.size());
    n = (rx_data_q.size() < exp_q.size()) ? rx_data_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_byte"}, rx_data_q[i], exp_q[i]);
      check({tag, "_bit_timing"}, rx_ok_q[i], 1'b1);
      if (i > 0) check({tag, "_gap"}, rx_start_q[i] - rx_start_q[i-1], FRAME_CYC);
    end
  endtask

  // Line receiver: samples every cycle, checks each bit is held DIV cycles.
  initial begin : rx_monitor
    bit         act = 1'b0;
    bit         ok  = 1'b1;
    int         c   = 0;
    int         bi  = 0;
    int         st  = 0;
    logic       cur = 1'b1;
    logic [7:0] sh  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        act = 1'b0;
      end else begin
        if (!act && txd === 1'b0) begin
          act = 1'b1;
          c   = 0;
          ok  = 1'b1;
          st  = cyc;
        end else if (act) begin
          c++;
        end
        if (act) begin
          bi = c / DIV;
          if (c % DIV == 0) cur = txd;
          else if (txd !== cur) ok = 1'b0;
          if (bi == 0 && txd !== 1'b0) ok = 1'b0;
          if (bi == 9 && txd !== 1'b1) ok = 1'b0;
          if (bi >= 1 && bi <= 8 && c % DIV == 0) sh[bi-1] = txd;
          if (c == FRAME_CYC - 1) begin
            rx_data_q.push_back(sh);
            rx_ok_q.push_back(ok);
            rx_start_q.push_back(st);
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    b_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr_overflow = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();

    // Single byte 0x55 written at edge N while idle
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    check("a_level_n", level, 3'd1);
    check("a_busy_n", busy, 1'b1);
    check("a_txd_n", txd, 1'b1);
    tick();
    check("a_txd_n1", txd, 1'b1);
    check("a_level_n1", level, 3'd0);
    tick();
    check("a_txd_n2", txd, 1'b0);
    repeat (38) tick();
    check("a_busy_n40", busy, 1'b1);
    repeat (2) tick();
    check("a_busy_n42", busy, 1'b0);
    check("a_txd_n42", txd, 1'b1);
    repeat (2) tick();
    check_rx("a");

    // Six writes in consecutive cycles; then a dropped write on the STOP->START pop
    do_reset();
    for (int k = 0; k < 6; k++) begin
      wr_en   = 1'b1;
      wr_data = 8'(k + 1);
      if (k < 5) exp_q.push_back(8'(k + 1));
      tick();
      check("b_level", level, b_lvl[k]);
      if (k == 4) begin
        check("b_ovf_after5", overflow, 1'b0);
        check("b_full_after5", full, 1'b1);
      end
    end
    wr_en = 1'b0;
    check("b_ovf_after6", overflow, 1'b1);
    check("b_full_after6", full, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("b_ovf_clr", overflow, 1'b0);
    repeat (34) tick();
    check("b_full_n40", full, 1'b1);
    check("b_level_n40", level, 3'd4);
    write_byte(8'hAA);
    check("b_level_pop_drop", level, 3'd3);
    check("b_ovf_pop_drop", overflow, 1'b1);
    check("b_full_pop_drop", full, 1'b0);
    wait_idle("b", 600);
    check_rx("b");

    // Clear coinciding with a dropped write keeps the flag set
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'(8'h11 + k));
      write_byte(8'(8'h11 + k));
    end
    check("c_full", full, 1'b1);
    wr_en        = 1'b1;
    wr_data      = 8'h99;
    clr_overflow = 1'b1;
    tick();
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    check("c_ovf_set_wins", overflow, 1'b1);
    check("c_level", level, 3'd4);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("c_ovf_clr", overflow, 1'b0);
    wait_idle("c", 600);
    check_rx("c");

    // Asynchronous reset during data bit 3, then normal operation
    do_reset();
    write_byte(8'hA5);
    write_byte(8'h3C);
    check("d_level_queued", level, 3'd1);
    repeat (17) tick();
    check("d_txd_bit3", txd, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("d_rst_txd", txd, 1'b1);
    check("d_rst_busy", busy, 1'b0);
    check("d_rst_level", level, 3'd0);
    check("d_rst_full", full, 1'b0);
    #6;
    rst_n = 1'b1;
    tick();
    rx_data_q.delete();
    rx_ok_q.delete();
    rx_start_q.delete();
    exp_q.delete();
    check("d_idle_after_rst", busy, 1'b0);
    exp_q.push_back(8'h3C);
    write_byte(8'h3C);
    wait_idle("d", 200);
    check_rx("d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
